cordic_seq_ctrl: RTL and testbench

Iterative sequencer for the two-stage CORDIC datapath (`doble_cordic`, two `cordic_unit` stages per pass). It accepts one rotation-mode job (vector plus angle) and feeds the external datapath once per clock, advancing the iteration index by 2 each pass. It supplies both arctangent constants from an internal table and presents the rotated vector and residual angle with a start/done handshake. It sits between the job source and a single shared datapath instance, so one datapath covers up to 8 micro-rotations.

---
 rtl/cordic_seq_ctrl_if.sv | 27 ++
 rtl/cordic_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_seq_ctrl_if.sv
// Job-side handshake bundle for cordic_seq_ctrl.
//   master : job source  - drives start/abort and the start vector/angle,
//                          receives busy/done and the held result.
//   slave  : controller  - the mirror image.
// All vector signals are two's complement; angles are in 0.5 degree LSBs.
interface cordic_seq_ctrl_if;
  logic               start;
  logic               abort;
  logic signed [18:0] x_in;
  logic signed [18:0] y_in;
  logic signed [8:0]  z_in;
  logic               busy;
  logic               done;
  logic signed [18:0] x_out;
  logic signed [18:0] y_out;
  logic signed [8:0]  z_out;

  modport master (
    output start, abort, x_in, y_in, z_in,
    input  busy, done, x_out, y_out, z_out
  );

  modport slave (
    input  start, abort, x_in, y_in, z_in,
    output busy, done, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Iterative sequencer for a shared two-stage CORDIC datapath (rotation mode).
// One job runs NPAIRS passes through the external datapath, one pass per
// clock, each pass covering iterations i and i+1.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   job (slave)          start/abort request, start vector/angle in,
//                        busy/done status, held result out
//   dc_vx, dc_vy, dc_z   working vector/angle driven to the datapath
//   dc_atan0, dc_atan1   atan(2^-i), atan(2^-(i+1)) in 0.5 degree units
//   dc_i                 iteration index of the first datapath stage
//   dc_rvx, dc_rvy,      datapath results, combinational from dc_*
//   dc_new_z
module cordic_seq_ctrl #(
  parameter int NPAIRS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cordic_seq_ctrl_if.slave   job,
  output logic signed [18:0] dc_vx,
  output logic signed [18:0] dc_vy,
  output logic signed [8:0]  dc_z,
  output logic signed [8:0]  dc_atan0,
  output logic signed [8:0]  dc_atan1,
  output logic        [2:0]  dc_i,
  input  logic signed [18:0] dc_rvx,
  input  logic signed [18:0] dc_rvy,
  input  logic signed [8:0]  dc_new_z
);

  typedef enum logic {IDLE, ITER} state_t;

  localparam logic [1:0] LAST_PAIR = 2'(NPAIRS - 1);

  state_t             state, state_nxt;
  logic [1:0]         pair;
  logic signed [18:0] vx, vy;
  logic signed [8:0]  z;
  logic signed [18:0] x_res, y_res;
  logic signed [8:0]  z_res;
  logic               done_q;
  logic               load, capture, finish;

  // Arctangent table, atan(2^-i) rounded to 0.5 degree steps.
  function automatic logic signed [8:0] atan_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    return 9'sd90;
      3'd1:    return 9'sd53;
      3'd2:    return 9'sd28;
      3'd3:    return 9'sd14;
      3'd4:    return 9'sd7;
      3'd5:    return 9'sd4;
      3'd6:    return 9'sd2;
      default: return 9'sd1;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        // abort is deliberately not looked at here.
        if (job.start) begin
          load      = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        // abort wins over the capture, including the final one, so an
        // aborted job never touches the result registers.
        if (job.abort) begin
          state_nxt = IDLE;
        end else begin
          capture = 1'b1;
          if (pair == LAST_PAIR) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vx     <= '0;
      vy     <= '0;
      z      <= '0;
      pair   <= '0;
      x_res  <= '0;
      y_res  <= '0;
      z_res  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        vx <= job.x_in;
        vy <= job.y_in;
        z  <= job.z_in;
      end else if (capture) begin
        vx <= dc_rvx;
        vy <= dc_rvy;
        z  <= dc_new_z;
      end
      // pair is parked at 0 whenever the controller is idle, so dc_i never
      // shows a stale index between jobs.
      if (load || state_nxt == IDLE) pair <= '0;
      else if (capture)              pair <= pair + 2'd1;
      if (finish) begin
        x_res <= dc_rvx;
        y_res <= dc_rvy;
        z_res <= dc_new_z;
      end
    end
  end

  assign job.busy  = (state == ITER);
  assign job.done  = done_q;
  assign job.x_out = x_res;
  assign job.y_out = y_res;
  assign job.z_out = z_res;

  assign dc_vx = vx;
  assign dc_vy = vy;
  assign dc_z  = z;
  assign dc_i  = {pair, 1'b0};
  // Constants are only presented while iterating so the idle datapath
  // inputs read as all zero.
  assign dc_atan0 = (state == ITER) ? atan_lut({pair, 1'b0}) : '0;
  assign dc_atan1 = (state == ITER) ? atan_lut({pair, 1'b1}) : '0;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: a behavioural two-stage CORDIC
// datapath closes the loop, expected results go into a queue per instance
// when a job is accepted and are compared when done pulses.
module tb_cordic_seq_ctrl;

  localparam int NP = 4;
  localparam logic signed [8:0] ATAN [8] = '{9'sd90, 9'sd53, 9'sd28, 9'sd14,
                                             9'sd7, 9'sd4, 9'sd2, 9'sd1};

  typedef struct packed {
    logic signed [18:0] x;
    logic signed [18:0] y;
    logic signed [8:0]  z;
  } vec_t;

  typedef struct {
    vec_t in;
    vec_t exp;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  vec_t q4[$];
  vec_t q1[$];
  vec_t exp4, exp1, last4;

  // ---------------- model of the external datapath ----------------
  function automatic vec_t cordic_stage(input vec_t v, input int i,
                                        input logic signed [8:0] a);
    logic signed [18:0] x, y, xs, ys;
    logic signed [8:0]  z;
    vec_t r;
    x = v.x; y = v.y; z = v.z;
    xs = x >>> i;
    ys = y >>> i;
    if (z >= 0) begin
      r.x = x - ys; r.y = y + xs; r.z = z - a;
    end else begin
      r.x = x + ys; r.y = y - xs; r.z = z + a;
    end
    return r;
  endfunction

  function automatic vec_t double_step(input vec_t v, input logic [2:0] i,
                                       input logic signed [8:0] a0,
                                       input logic signed [8:0] a1);
    vec_t s1;
    s1 = cordic_stage(v, int'(i), a0);
    return cordic_stage(s1, int'(i) + 1, a1);
  endfunction

  // Full job reference: iterations 0..2*np-1 with the known atan table.
  function automatic vec_t ref_job(input vec_t in, input int np);
    vec_t v;
    v = in;
    for (int i = 0; i < 2 * np; i++) v = cordic_stage(v, i, ATAN[i]);
    return v;
  endfunction

  function automatic vec_t mk(input int x, input int y, input int z);
    vec_t r;
    r.x = 19'(x); r.y = 19'(y); r.z = 9'(z);
    return r;
  endfunction

  // ---------------- DUT with NPAIRS = 4 ----------------
  cordic_seq_ctrl_if j4 ();
  logic signed [18:0] dc_vx4, dc_vy4, dc_rvx4, dc_rvy4;
  logic signed [8:0]  dc_z4, dc_atan04, dc_atan14, dc_new_z4;
  logic [2:0]         dc_i4;
  vec_t               dp4;

  cordic_seq_ctrl #(.NPAIRS(NP)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .job(j4),
    .dc_vx(dc_vx4), .dc_vy(dc_vy4), .dc_z(dc_z4),
    .dc_atan0(dc_atan04), .dc_atan1(dc_atan14), .dc_i(dc_i4),
    .dc_rvx(dc_rvx4), .dc_rvy(dc_rvy4), .dc_new_z(dc_new_z4)
  );

  assign dp4       = double_step({dc_vx4, dc_vy4, dc_z4}, dc_i4, dc_atan04, dc_atan14);
  assign dc_rvx4   = dp4.x;
  assign dc_rvy4   = dp4.y;
  assign dc_new_z4 = dp4.z;

  // ---------------- DUT with NPAIRS = 1 ----------------
  cordic_seq_ctrl_if j1 ();
  logic signed [18:0] dc_vx1, dc_vy1, dc_rvx1, dc_rvy1;
  logic signed [8:0]  dc_z1, dc_atan01, dc_atan11, dc_new_z1;
  logic [2:0]         dc_i1;
  vec_t               dp1;

  cordic_seq_ctrl #(.NPAIRS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .job(j1),
    .dc_vx(dc_vx1), .dc_vy(dc_vy1), .dc_z(dc_z1),
    .dc_atan0(dc_atan01), .dc_atan1(dc_atan11), .dc_i(dc_i1),
    .dc_rvx(dc_rvx1), .dc_rvy(dc_rvy1), .dc_new_z(dc_new_z1)
  );

  assign dp1       = double_step({dc_vx1, dc_vy1, dc_z1}, dc_i1, dc_atan01, dc_atan11);
  assign dc_rvx1   = dp1.x;
  assign dc_rvy1   = dp1.y;
  assign dc_new_z1 = dp1.z;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp,
                            input int tol);
    int d;
    n_checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Scoreboards: compare the held result on the cycle done is high.
  always @(negedge clk) begin
    if (rst_n && j4.done) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL res4_unexpected_done: got done=1, expected no done");
      end else begin
        exp4 = q4.pop_front();
        check("res4", {j4.x_out, j4.y_out, j4.z_out}, exp4);
        last4 = exp4;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && j1.done) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL res1_unexpected_done: got done=1, expected no done");
      end else begin
        exp1 = q1.pop_front();
        check("res1", {j1.x_out, j1.y_out, j1.z_out}, exp1);
      end
    end
  end

  // Drive one start pulse; returns #1 after the accepting edge.
  task automatic issue4(input vec_t in, input vec_t exp, input bit push);
    @(negedge clk);
    j4.start = 1'b1;
    j4.x_in  = in.x; j4.y_in = in.y; j4.z_in = in.z;
    @(posedge clk); #1;
    j4.start = 1'b0;
    j4.x_in  = 19'($urandom); j4.y_in = 19'($urandom); j4.z_in = 9'($urandom);
    if (push) q4.push_back(exp);
    check("busy_after_start", j4.busy, 1);
  endtask

  task automatic check_seq4(input int p);
    if (p < NP)
      check($sformatf("seq_pair%0d", p), {dc_i4, dc_atan04, dc_atan14},
            {3'(2 * p), ATAN[2 * p], ATAN[2 * p + 1]});
  endtask

  // Count edges until done, bounded.
  task automatic wait_done4(input bit chk_seq, output int edges);
    edges = 0;
    while (!j4.done && edges < 16) begin
      if (chk_seq && j4.busy) check_seq4(edges);
      @(posedge clk); #1;
      edges++;
    end
    if (!j4.done) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d edges, expected done", edges);
    end
  endtask

  task automatic count_done4(input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (j4.done) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_rec_t tv[7];
    vec_t a_in, b_in, junk, zero;
    int e, seen;

    tv[0].in = mk(100000, 0, 60);
    tv[1].in = mk(0, 50000, -90);
    tv[2].in = mk(-70000, 30000, 150);
    tv[3].in = mk(12345, -54321, -198);
    tv[4].in = mk(120000, -80000, 198);
    tv[5].in = mk(0, 0, 0);
    tv[6].in = mk(777, 99999, -256);
    for (int k = 0; k < 7; k++) tv[k].exp = ref_job(tv[k].in, NP);
    zero = '0;

    j4.start = 1'b0; j4.abort = 1'b0; j4.x_in = '0; j4.y_in = '0; j4.z_in = '0;
    j1.start = 1'b0; j1.abort = 1'b0; j1.x_in = '0; j1.y_in = '0; j1.z_in = '0;
    last4 = '0;

    // Reset state
    #12;
    check("rst_status", {j4.busy, j4.done}, 0);
    check("rst_result", {j4.x_out, j4.y_out, j4.z_out}, 0);
    check("rst_dc", {dc_vx4, dc_vy4, dc_z4, dc_atan04, dc_atan14, dc_i4}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven jobs
    for (int k = 0; k < 7; k++) begin
      issue4(tv[k].in, tv[k].exp, 1'b1);
      if (k == 0) check("dc_load", {dc_vx4, dc_vy4, dc_z4}, tv[k].in);
      wait_done4(1'b1, e);
      check($sformatf("latency_v%0d", k), e, NP);
      if (k == 0) begin
        check_near("basic_x", int'(j4.x_out), 142600, 1426);
        check_near("basic_y", int'(j4.y_out), 82300, 823);
        check_near("basic_z", int'(j4.z_out), 0, 2);
      end
      @(posedge clk); #1;
      check($sformatf("done_pulse_v%0d", k), {j4.done, j4.busy}, 0);
    end

    // Back-to-back: B's start is high on the edge where A's done is high
    a_in = mk(0, 50000, -90);
    b_in = mk(-30000, 40000, 100);
    issue4(a_in, ref_job(a_in, NP), 1'b1);
    wait_done4(1'b0, e);
    check("latency_A", e, NP);
    check_near("negA_x", int'(j4.x_out), 58200, 582);
    check_near("negA_y", int'(j4.y_out), 58200, 582);
    j4.start = 1'b1;
    j4.x_in = b_in.x; j4.y_in = b_in.y; j4.z_in = b_in.z;
    @(posedge clk); #1;
    j4.start = 1'b0;
    q4.push_back(ref_job(b_in, NP));
    check("b2b_accept", j4.busy, 1);
    wait_done4(1'b0, e);
    check("b2b_done_gap", e + 1, NP + 1);

    // start during ITER is ignored and not queued
    junk = mk(11111, 22222, 33);
    issue4(tv[2].in, tv[2].exp, 1'b1);
    j4.start = 1'b1;
    j4.x_in = junk.x; j4.y_in = junk.y; j4.z_in = junk.z;
    @(posedge clk); #1;
    j4.start = 1'b0;
    wait_done4(1'b0, e);
    check("ignore_start_latency", e + 1, NP);
    @(posedge clk); #1;
    check("ignore_start_not_queued", j4.busy, 0);

    // abort in pair 2
    issue4(tv[3].in, tv[3].exp, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    j4.abort = 1'b1;
    @(posedge clk); #1;
    j4.abort = 1'b0;
    check("abort_idle", {j4.busy, j4.done}, 0);
    check("abort_hold", {j4.x_out, j4.y_out, j4.z_out}, last4);
    count_done4(6, seen);
    check("abort_no_done", seen, 0);

    // abort on the completing capture
    issue4(tv[4].in, tv[4].exp, 1'b0);
    repeat (NP - 1) begin @(posedge clk); #1; end
    j4.abort = 1'b1;
    @(posedge clk); #1;
    j4.abort = 1'b0;
    check("abort_last_status", {j4.busy, j4.done}, 0);
    check("abort_last_hold", {j4.x_out, j4.y_out, j4.z_out}, last4);

    // abort in IDLE does not block start
    @(negedge clk);
    j4.abort = 1'b1; j4.start = 1'b1;
    j4.x_in = tv[6].in.x; j4.y_in = tv[6].in.y; j4.z_in = tv[6].in.z;
    @(posedge clk); #1;
    j4.abort = 1'b0; j4.start = 1'b0;
    q4.push_back(tv[6].exp);
    check("idle_abort_start", j4.busy, 1);
    wait_done4(1'b0, e);
    check("idle_abort_latency", e, NP);

    // Reset mid-ITER (pair 1)
    issue4(tv[0].in, tv[0].exp, 1'b0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_status", {j4.busy, j4.done}, 0);
    check("rst_mid_result", {j4.x_out, j4.y_out, j4.z_out}, zero);
    check("rst_mid_dc", {dc_vx4, dc_vy4, dc_z4, dc_atan04, dc_atan14, dc_i4}, 0);
    count_done4(4, seen);
    check("rst_mid_no_done", seen, 0);
    last4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue4(tv[1].in, tv[1].exp, 1'b1);
    wait_done4(1'b1, e);
    check("after_rst_latency", e, NP);

    // NPAIRS = 1 instance
    @(negedge clk);
    j1.start = 1'b1; j1.x_in = 19'sd1000; j1.y_in = '0; j1.z_in = '0;
    @(posedge clk); #1;
    j1.start = 1'b0;
    q1.push_back(ref_job(mk(1000, 0, 0), 1));
    check("np1_seq", {j1.busy, dc_i1, dc_atan01, dc_atan11},
          {1'b1, 3'd0, 9'sd90, 9'sd53});
    @(posedge clk); #1;
    check("np1_done", {j1.done, j1.busy}, 2'b10);
    check("np1_z_out", j1.z_out, -37);
    @(posedge clk); #1;
    check("np1_done_pulse", {j1.done, dc_i1}, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", q4.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
